// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared definitions for the store buffer slice: the machine word width,
//   the default buffer depth and its pointer width, boolean constants, and
//   the packed {addr, data} entry type that the FIFO storage and the
//   forwarding selector both use.
package store_buffer_pkg;

    localparam int XLEN_WIDTH   = 32;
    localparam int SB_DEPTH     = 4;
    localparam int SB_PTR_WIDTH = $clog2(SB_DEPTH);

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [XLEN_WIDTH-1:0] xlen_t;

    typedef struct packed {
        xlen_t addr;
        xlen_t data;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward.sv
// sb_forward
//   Combinational youngest-match selector for store-to-load forwarding.
//   Walks the valid entries from the most recently written one (tail-1)
//   back towards the oldest (head) and returns the data of the first
//   entry whose address equals the load address.
//
// Ports
//   entries_i    : all buffer entries, indexed by physical slot
//   tail_i       : slot the next store will be written to
//   count_i      : number of valid entries (0..SB_DEPTH)
//   read_addr_i  : load address to look up
//   hit_o        : some valid entry matches read_addr_i
//   data_o       : data of the youngest matching entry (0 when no hit)
module sb_forward
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic [PTR_W-1:0]      tail_i,
    input  logic [PTR_W:0]        count_i,
    input  xlen_t                 read_addr_i,
    output logic                  hit_o,
    output xlen_t                 data_o
);

    logic [PTR_W-1:0] idx;

    // The i-th step back from tail lands on slot tail-1-i; modulo wrap comes
    // for free from the pointer width because DEPTH is a power of two. Only
    // the first count_i steps cover valid entries, and the first hit wins so
    // the youngest matching store is forwarded.
    always_comb begin
        hit_o  = FALSE;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail_i - PTR_W'(i + 1);
            if (!hit_o && (i < int'(count_i)) &&
                (entries_i[idx].addr == read_addr_i)) begin
                hit_o  = TRUE;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Circular FIFO of pending stores between the mem stage and the data RAM.
//   Stores are accepted at the tail, drained in strict order from the head
//   whenever the RAM is ready, and loads see the youngest pending data for
//   their address before falling back to the RAM.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   in_write_en/addr/data : store request from the mem stage
//   in_read_addr     : load address from the mem stage
//   in_read_data     : forwarded / RAM load data (combinational)
//   ram_read_addr/data    : data RAM read port (pass-through address)
//   ram_write_en/addr/data: drain request carrying the head entry
//   ram_write_ready  : RAM takes the drain write this cycle
//   full, empty      : occupancy flags
//   pause_signal     : store presented but not accepted; pipeline holds
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int SB_DEPTH = store_buffer_pkg::SB_DEPTH
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  in_write_en,
    input  xlen_t in_write_addr,
    input  xlen_t in_write_data,
    input  xlen_t in_read_addr,
    output xlen_t in_read_data,
    output xlen_t ram_read_addr,
    input  xlen_t ram_read_data,
    output logic  ram_write_en,
    output xlen_t ram_write_addr,
    output xlen_t ram_write_data,
    input  logic  ram_write_ready,
    output logic  full,
    output logic  empty,
    output logic  pause_signal
);

    localparam int PtrW = $clog2(SB_DEPTH);
    localparam int CntW = PtrW + 1;

    sb_entry_t [SB_DEPTH-1:0] entries_q, entries_d;
    logic [PtrW-1:0]          head_q, head_d;
    logic [PtrW-1:0]          tail_q, tail_d;
    logic [CntW-1:0]          count_q, count_d;

    logic  drain;
    logic  accept;
    logic  fwdHit;
    xlen_t fwdData;

    // Occupancy flags and the drain port come purely from registered state,
    // so a store written into an empty buffer cannot leave in the same cycle.
    always_comb begin
        full           = (count_q == CntW'(SB_DEPTH));
        empty          = (count_q == '0);
        ram_write_en   = !empty;
        ram_write_addr = empty ? '0 : entries_q[head_q].addr;
        ram_write_data = empty ? '0 : entries_q[head_q].data;
    end

    // A full buffer can still take a store when the head leaves this cycle,
    // which keeps the pipeline moving at full occupancy.
    always_comb begin
        drain        = ram_write_en && ram_write_ready;
        accept       = in_write_en && (!full || drain);
        pause_signal = in_write_en && !accept;
    end

    // Pointer and count bookkeeping; pointers wrap through their natural
    // width since the depth is a power of two.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CntW'(accept) - CntW'(drain);
        if (accept) begin
            entries_d[tail_q].addr = in_write_addr;
            entries_d[tail_q].data = in_write_data;
            tail_d                 = tail_q + PtrW'(1);
        end
        if (drain) begin
            head_d = head_q + PtrW'(1);
        end
    end

    // Reset clears only the bookkeeping; stale entry contents are invisible
    // once count is zero, so the storage array needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    // The head entry keeps forwarding while it drains, because the scan
    // covers every entry counted in count_q.
    sb_forward #(
        .DEPTH (SB_DEPTH),
        .PTR_W (PtrW)
    ) u_forward (
        .entries_i   (entries_q),
        .tail_i      (tail_q),
        .count_i     (count_q),
        .read_addr_i (in_read_addr),
        .hit_o       (fwdHit),
        .data_o      (fwdData)
    );

    // A store arriving this very cycle is the youngest of all, ahead of
    // anything already buffered.
    always_comb begin
        ram_read_addr = in_read_addr;
        if (in_write_en && (in_write_addr == in_read_addr)) begin
            in_read_data = in_write_data;
        end else if (fwdHit) begin
            in_read_data = fwdData;
        end else begin
            in_read_data = ram_read_data;
        end
    end

endmodule
